// File: rtl/f_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: exception codes, next-PC op
// encodings and the default PC constants.
package f_fetch_stage_pkg;

    // CP0 exception codes carried down the pipeline
    localparam logic [4:0] EXC_NONE = 5'd31;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Next-PC kind decided by the D stage
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;

    // Word-aligned, sign-extended branch displacement
    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/f_fetch_stage_npc_calc.sv
// Combinational next-PC selection from the D-stage branch/jump decision.
module npc_calc
    import f_fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] d_pc_i,
    input  logic [1:0]  op_i,
    input  logic        taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] idx26_i,
    input  logic [31:0] rs_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;

    // PC+4 wraps naturally mod 2^32; branch target is relative to the
    // instruction in D because F already holds its delay slot.
    assign seq_pc = pc_i + 32'd4;
    assign br_pc  = d_pc_i + 32'd4 + br_offset(imm16_i);

    // Select the next PC by op kind
    always_comb begin
        npc_o = seq_pc;
        case (npc_op_e'(op_i))
            NPC_SEQ: npc_o = seq_pc;
            NPC_BR:  npc_o = taken_i ? br_pc : seq_pc;
            NPC_J:   npc_o = {d_pc_i[31:28], idx26_i, 2'b00};
            NPC_JR:  npc_o = rs_i;
            default: npc_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: architectural PC register, next-PC update with redirect
// priority matching the F/D register, and AdEL screening of the fetch address.
module f_fetch_stage
    import f_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        IntReq,
    input  logic        clr_delay,
    input  logic [31:0] EPC,
    input  logic [31:0] D_PC_i,
    input  logic [1:0]  D_npc_op_i,
    input  logic        D_br_taken_i,
    input  logic [15:0] D_imm16_i,
    input  logic [25:0] D_idx26_i,
    input  logic [31:0] D_rs_i,
    input  logic [31:0] im_rdata_i,
    output logic [31:0] im_addr_o,
    output logic [31:0] F_PC_o,
    output logic [31:0] F_Instr_o,
    output logic [4:0]  F_excCode_o,
    output logic        F_bd_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] npc;
    logic        adel;

    npc_calc u_npc_calc (
        .pc_i    (pc_q),
        .d_pc_i  (D_PC_i),
        .op_i    (D_npc_op_i),
        .taken_i (D_br_taken_i),
        .imm16_i (D_imm16_i),
        .idx26_i (D_idx26_i),
        .rs_i    (D_rs_i),
        .npc_o   (npc)
    );

    // PC update priority: exception entry, then stall hold, then eret, then NPC.
    // A stalled eret is simply re-presented by D next cycle.
    always_comb begin
        pc_d = npc;
        if (IntReq)
            pc_d = HANDLER_PC;
        else if (stall)
            pc_d = pc_q;
        else if (clr_delay)
            pc_d = EPC;
    end

    // PC register; reset overrides any pending redirect or stall
    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    // Misaligned or out-of-window fetch; illegal jr targets land here too
    always_comb begin
        adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    end

    assign im_addr_o   = pc_q;
    assign F_PC_o      = pc_q;
    assign F_Instr_o   = adel ? 32'h0 : im_rdata_i;
    assign F_excCode_o = adel ? EXC_ADEL : EXC_NONE;
    assign F_bd_o      = (D_npc_op_i != NPC_SEQ);

endmodule
